dram_cmd_sched: RTL

Closed-page DRAM command scheduler sitting directly downstream of the request queue. It accepts one aged memory request at a time, decodes its address into bank group, bank, row and column, and issues the ACT, RD/WR and PRE command sequence. The sequence is spaced by DDR4 timing constraints counted in DIMM cycles, where one DIMM cycle equals two CPU cycles. Its command outputs feed the trace/log writer.

---
 rtl/dram_cmd_sched_if.sv | 49 ++++
 rtl/dram_cmd_sched.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/dram_cmd_sched_if.sv
// Request/command bundle between the request queue,
// the DRAM command scheduler and the trace writer.
interface dram_cmd_sched_if;
  logic        req_valid;
  logic [1:0]  req_opcode;
  logic [32:0] req_address;
  logic        req_ready;
  logic        cmd_valid;
  logic [1:0]  cmd;
  logic [1:0]  cmd_bg;
  logic [1:0]  cmd_bank;
  logic [14:0] cmd_row;
  logic [10:0] cmd_col;
  logic        done;
  logic        err;
  logic [31:0] dimm_time;

  modport master (
    output req_valid,
    output req_opcode,
    output req_address,
    input  req_ready,
    input  cmd_valid,
    input  cmd,
    input  cmd_bg,
    input  cmd_bank,
    input  cmd_row,
    input  cmd_col,
    input  done,
    input  err,
    input  dimm_time
  );

  modport slave (
    input  req_valid,
    input  req_opcode,
    input  req_address,
    output req_ready,
    output cmd_valid,
    output cmd,
    output cmd_bg,
    output cmd_bank,
    output cmd_row,
    output cmd_col,
    output done,
    output err,
    output dimm_time
  );
endinterface

// File: rtl/dram_cmd_sched.sv
// Closed-page DRAM command scheduler: ACT, RD/WR, PRE
// per request, spaced in DIMM cycles (2 CPU cycles each).
module dram_cmd_sched #(
  parameter int T_RCD   = 24,
  parameter int T_CL    = 24,
  parameter int T_CWL   = 20,
  parameter int T_BURST = 4,
  parameter int T_RAS   = 52,
  parameter int T_RP    = 24
) (
  input logic CPU_clock,
  input logic rst_n,
  dram_cmd_sched_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    ACT,
    WAIT_RCD,
    CAS,
    WAIT_PRE,
    PRE,
    WAIT_RP
  } state_t;

  localparam logic [1:0] CMD_ACT = 2'd0;
  localparam logic [1:0] CMD_RD  = 2'd1;
  localparam logic [1:0] CMD_WR  = 2'd2;
  localparam logic [1:0] CMD_PRE = 2'd3;

  // CAS->PRE gap: tRAS remainder or data burst end
  localparam int RD_SPAN  = T_CL + T_BURST;
  localparam int WR_SPAN  = T_CWL + T_BURST;
  localparam int RAS_SPAN = T_RAS - T_RCD;
  localparam logic [8:0] RD_GAP9 =
    9'((RAS_SPAN > RD_SPAN) ? RAS_SPAN : RD_SPAN);
  localparam logic [8:0] WR_GAP9 =
    9'((RAS_SPAN > WR_SPAN) ? RAS_SPAN : WR_SPAN);
  localparam logic [7:0] RD_GAP  = RD_GAP9[7:0];
  localparam logic [7:0] WR_GAP  = WR_GAP9[7:0];
  localparam logic [7:0] RCD_GAP = 8'(T_RCD);
  localparam logic [7:0] RP_GAP  = 8'(T_RP);

  state_t      state;
  logic        phase;
  logic        pend;
  logic        wr_q;
  logic [32:3] addr_q;
  logic [7:0]  cnt;
  logic [7:0]  nxt;
  logic [7:0]  pre_gap;

  assign nxt     = cnt + 8'd1;
  assign pre_gap = wr_q ? WR_GAP : RD_GAP;

  always_ff @(posedge CPU_clock) begin
    if (!rst_n) begin
      state         <= IDLE;
      phase         <= 1'b0;
      pend          <= 1'b0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      cnt           <= '0;
      bus.req_ready <= 1'b1;
      bus.cmd_valid <= 1'b0;
      bus.cmd       <= CMD_ACT;
      bus.cmd_bg    <= '0;
      bus.cmd_bank  <= '0;
      bus.cmd_row   <= '0;
      bus.cmd_col   <= '0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.dimm_time <= '0;
    end else begin
      phase    <= ~phase;
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      if (bus.req_valid && bus.req_ready) begin
        addr_q        <= bus.req_address[32:3];
        wr_q          <= (bus.req_opcode == 2'd1);
        bus.req_ready <= 1'b0;
        if (bus.req_opcode == 2'd3)
          bus.err <= 1'b1;
        else
          pend <= 1'b1;
      end else if (state == IDLE && !pend) begin
        bus.req_ready <= 1'b1;
      end
      if (phase) begin
        bus.dimm_time <= bus.dimm_time + 32'd1;
        unique case (state)
          IDLE: begin
            if (pend) begin
              state         <= ACT;
              pend          <= 1'b0;
              cnt           <= '0;
              bus.cmd_valid <= 1'b1;
              bus.cmd       <= CMD_ACT;
              bus.cmd_bg    <= addr_q[7:6];
              bus.cmd_bank  <= addr_q[9:8];
              bus.cmd_row   <= addr_q[32:18];
              bus.cmd_col   <= {addr_q[17:10],
                                addr_q[5:3]};
            end
          end
          ACT, WAIT_RCD: begin
            if (nxt == RCD_GAP) begin
              state         <= CAS;
              cnt           <= '0;
              bus.cmd_valid <= 1'b1;
              bus.cmd       <= wr_q ? CMD_WR : CMD_RD;
            end else begin
              state         <= WAIT_RCD;
              cnt           <= nxt;
              bus.cmd_valid <= 1'b0;
              bus.cmd       <= CMD_ACT;
            end
          end
          CAS, WAIT_PRE: begin
            if (nxt == pre_gap) begin
              state         <= PRE;
              cnt           <= '0;
              bus.cmd_valid <= 1'b1;
              bus.cmd       <= CMD_PRE;
            end else begin
              state         <= WAIT_PRE;
              cnt           <= nxt;
              bus.cmd_valid <= 1'b0;
              bus.cmd       <= CMD_ACT;
            end
          end
          PRE, WAIT_RP: begin
            bus.cmd_valid <= 1'b0;
            bus.cmd       <= CMD_ACT;
            if (nxt == RP_GAP) begin
              state         <= IDLE;
              cnt           <= '0;
              bus.done      <= 1'b1;
              bus.req_ready <= 1'b1;
              bus.cmd_bg    <= '0;
              bus.cmd_bank  <= '0;
              bus.cmd_row   <= '0;
              bus.cmd_col   <= '0;
            end else begin
              state <= WAIT_RP;
              cnt   <= nxt;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
